audio_conditioner: RTL and testbench
====================================

# audio_conditioner

Post-processing stage that sits directly downstream of the sound block and consumes its 16-bit unsigned mix. It turns that mix into a clean signed sample stream for the framework audio port. Per output sample it does four things:
- removes DC with a first-order high-pass;
- smooths POKEY/discrete edges with a first-order low-pass;
- applies a click-free mute/enable gain ramp;
- saturates the result to signed 16-bit.

All arithmetic is sequenced through a small state machine at one step per clock.

## Interface
Parameters:
- HP_SHIFT, 8, DC-block pole: y feedback is y_prev − (y_prev >>> HP_SHIFT).
- LP_SHIFT, 2, low-pass coefficient 2^-LP_SHIFT.
- RAMP_STEP, 64, gain change per accepted sample; gain full scale is 256.
- ACC_W, 20, signed internal datapath width.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- sample_en  in  1  one-cycle pulse in the clk domain at output sample rate (48 kHz).
- sound_en  in  1  sound enable from the core; 0 ramps gain to 0.
- mute  in  1  OSD/pause mute; 1 ramps gain to 0.
- audio_in  in  16  unsigned offset-binary mix from the sound block.
- audio_out  out  16  signed conditioned sample; holds its value between updates.
- out_valid  out  1  one-cycle pulse when audio_out updates.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when sample_en arrives while busy. Cleared only by reset.

## Operation
- States: IDLE → HPF → LPF → GAIN → OUT → IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - On sample_en, capture x = {~audio_in[15], audio_in[14:0]}, sign-extended to ACC_W. This is the signed conversion.
  - Update gain toward target, where target = 256 if (sound_en & ~mute) else 0.
  - The gain step is ±RAMP_STEP, clamped to 0..256. The updated gain is the one used for this sample.
- HPF: y = x − x_prev + y_prev − (y_prev >>> HP_SHIFT). Then x_prev ← x and y_prev ← y. Arithmetic shift.
- LPF: z ← z + ((y − z) >>> LP_SHIFT).
- GAIN: p = (z × gain) >>> 8, computed at ACC_W+9 bits with no truncation before the shift.
- OUT:
  - audio_out ← p saturated to −32768..32767. Values clamp and never wrap.
  - out_valid = 1 for this cycle only.
- Filter state (x_prev, y_prev, z) keeps running while gain = 0, so unmuting does not pop.
- sample_en while busy (HPF..OUT) is dropped and sets overrun. sample_en in the same cycle as OUT is also dropped, because it is accepted only in IDLE.
- Reset values:
  - state IDLE;
  - audio_out 0, out_valid 0, busy 0, overrun 0;
  - gain 0;
  - x_prev, y_prev, z all 0.
- Reset asserted mid-sequence abandons the sample with no out_valid. Every output takes its reset value on the next edge.

## Timing
- Latency: sample_en in cycle N (state IDLE) gives out_valid and the new audio_out at cycle N+4.
- Minimum accepted sample_en spacing is 5 cycles. At 48 kHz this leaves large margin at any core clock.
- Gain ramp from 0 to full takes 4 accepted samples: 64, 128, 192, 256. Full to 0 also takes 4 samples.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package audio_pkg holds:
  - the state enum typedef (IDLE, HPF, LPF, GAIN, OUT);
  - GAIN_FULL = 256;
  - the saturate-to-16 function.
- One natural sub-module is audio_sat_mul. It does the gain multiply, shift and saturation (GAIN → OUT path) and is reusable by other audio stages.
- Expected RTL size: ~150–250 lines including the sub-module.

## Test plan
- Reset with rst=0 for 3 cycles, then audio_in=16'h8000, sound_en=1, mute=0, 10 sample_en pulses. Required: audio_out=0 on every out_valid, and out_valid exactly 4 cycles after each pulse.
- Gain ramp at full gain (≥4 prior samples at audio_in=16'h8000). Step audio_in to 16'hC000. Required first output: y=16384, z=4096, audio_out=4096. Constant input afterward decays toward 0 (DC block).
- Mute: with gain at 256, assert mute. Required: the next 4 samples use gains 192, 128, 64, 0, and all later audio_out=0. Deassert mute, then gain ramps 64, 128, 192, 256.
- Saturation: settle at audio_in=16'h0000, then step to 16'hFFFF at full gain. audio_out must clamp at 16'h7FFF (never negative) while the overshoot exceeds range.
- Overrun: pulse sample_en at N and N+2. Required: a single out_valid at N+4, overrun=1 from N+3 onward, and filter state advanced once.
- Reset mid-op: assert rst=0 in the LPF cycle. Required: no out_valid, all outputs 0, state IDLE, and overrun cleared on the next edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio conditioning path: sequencer state
// encoding, gain full-scale constant, sample width and the saturate-to-16 helper.
package audio_pkg;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned GAIN_W    = 9;
    localparam int unsigned GAIN_FULL = 256;
    localparam int unsigned SAT_IN_W  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HPF  = 3'd1,
        LPF  = 3'd2,
        GAIN = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Clamp a wide signed value into the signed 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > 32'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_conditioner_if.sv
// Sample bus between the sound block / core controls and the conditioner.
//   sample_en : sample-rate strobe          sound_en : core sound enable
//   mute      : OSD/pause mute              audio_in : unsigned offset-binary mix
//   audio_out : two's complement sample     out_valid: one-cycle update strobe
//   busy      : sequencer not idle          overrun  : sticky dropped-strobe flag
interface audio_conditioner_if;
    import audio_pkg::*;

    logic                sample_en;
    logic                sound_en;
    logic                mute;
    logic [SAMPLE_W-1:0] audio_in;
    logic [SAMPLE_W-1:0] audio_out;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_en, sound_en, mute, audio_in,
        input  audio_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_en, sound_en, mute, audio_in,
        output audio_out, out_valid, busy, overrun
    );

endinterface

// File: rtl/audio_sat_mul.sv
// Gain multiply, >>>8 rescale and saturation to a signed 16-bit sample.
//   z        : signed filtered sample (ACC_W bits)
//   gain     : unsigned gain, 256 = unity
//   result_c : combinational saturated product
module audio_sat_mul
    import audio_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic signed [ACC_W-1:0]    z,
    input  logic        [GAIN_W-1:0]   gain,
    output logic signed [SAMPLE_W-1:0] result_c
);

    localparam int unsigned PROD_W = ACC_W + GAIN_W;

    logic signed [PROD_W-1:0] z_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;

    // Full-width product; gain is zero-extended so it stays non-negative.
    always_comb begin
        z_ext    = PROD_W'(z);
        gain_ext = $signed(PROD_W'(gain));
        prod     = z_ext * gain_ext;
        scaled   = prod >>> 8;
        result_c = sat16(SAT_IN_W'(scaled));
    end

endmodule

// File: rtl/audio_conditioner.sv
// Converts the sound block's unsigned mix into a conditioned signed stream:
// DC-blocking high-pass, edge-smoothing low-pass, click-free gain ramp and
// saturation, sequenced one step per clock after each accepted sample_en.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : audio_conditioner_if.slave (sample in, conditioned sample out, status)
module audio_conditioner
    import audio_pkg::*;
#(
    parameter int unsigned HP_SHIFT  = 8,
    parameter int unsigned LP_SHIFT  = 2,
    parameter int unsigned RAMP_STEP = 64,
    parameter int unsigned ACC_W     = 20
) (
    input logic                clk,
    input logic                rst,
    audio_conditioner_if.slave bus
);

    localparam int unsigned STEP_W = GAIN_W + 1;

    state_t state;
    state_t next_state;

    logic signed [ACC_W-1:0]    x;
    logic signed [ACC_W-1:0]    x_prev;
    logic signed [ACC_W-1:0]    y_prev;
    logic signed [ACC_W-1:0]    z;
    logic        [GAIN_W-1:0]   gain;
    logic signed [SAMPLE_W-1:0] audio_out_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic                       overrun_q;

    logic                       capture_c;
    logic                       hpf_c;
    logic                       lpf_c;
    logic                       out_load_c;
    logic                       overrun_set_c;

    logic signed [ACC_W-1:0]    x_in_c;
    logic signed [ACC_W-1:0]    y_c;
    logic signed [ACC_W-1:0]    z_c;
    logic        [GAIN_W-1:0]   gain_c;
    logic        [STEP_W-1:0]   gain_up_c;
    logic signed [SAMPLE_W-1:0] sat_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept a sample only in IDLE, then walk the pipeline once.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.sample_en) next_state = HPF;
            HPF:     next_state = LPF;
            LPF:     next_state = GAIN;
            GAIN:    next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        capture_c     = 1'b0;
        hpf_c         = 1'b0;
        lpf_c         = 1'b0;
        out_load_c    = 1'b0;
        case (state)
            IDLE:    capture_c  = bus.sample_en;
            HPF:     hpf_c      = 1'b1;
            LPF:     lpf_c      = 1'b1;
            GAIN:    out_load_c = 1'b1;
            default: ;
        endcase
        overrun_set_c = bus.sample_en && (state != IDLE);
    end

    // Arithmetic for each step; inverting the MSB turns offset binary into two's complement.
    always_comb begin
        x_in_c    = ACC_W'($signed({~bus.audio_in[SAMPLE_W-1], bus.audio_in[SAMPLE_W-2:0]}));
        y_c       = x - x_prev + y_prev - (y_prev >>> HP_SHIFT);
        z_c       = z + ((y_prev - z) >>> LP_SHIFT);
        gain_up_c = STEP_W'(gain) + STEP_W'(RAMP_STEP);
        gain_c    = '0;
        if (bus.sound_en && !bus.mute) begin
            gain_c = (gain_up_c > STEP_W'(GAIN_FULL)) ? GAIN_W'(GAIN_FULL) : GAIN_W'(gain_up_c);
        end else if (gain >= GAIN_W'(RAMP_STEP)) begin
            gain_c = gain - GAIN_W'(RAMP_STEP);
        end
    end

    audio_sat_mul #(
        .ACC_W (ACC_W)
    ) u_sat_mul (
        .z        (z),
        .gain     (gain),
        .result_c (sat_c)
    );

    // Datapath and output registers; filter state runs regardless of gain.
    // Output loads on the GAIN edge so out_valid is high during OUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x           <= '0;
            x_prev      <= '0;
            y_prev      <= '0;
            z           <= '0;
            gain        <= '0;
            audio_out_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_load_c;
            busy_q      <= (next_state != IDLE);
            if (overrun_set_c) begin
                overrun_q <= 1'b1;
            end
            if (capture_c) begin
                x    <= x_in_c;
                gain <= gain_c;
            end
            if (hpf_c) begin
                x_prev <= x;
                y_prev <= y_c;
            end
            if (lpf_c) begin
                z <= z_c;
            end
            if (out_load_c) begin
                audio_out_q <= sat_c;
            end
        end
    end

    assign bus.audio_out = audio_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_audio_conditioner.sv
// Self-checking bench for audio_conditioner: directed scenarios plus random
// stimulus, compared every cycle against a sample-level arithmetic model.
module tb_audio_conditioner;

    localparam int     NC    = 8000;
    localparam longint HP    = 8;
    localparam longint LP    = 2;
    localparam longint STEP  = 64;
    localparam longint FULL  = 256;

    logic clk = 1'b0;
    logic rst;

    audio_conditioner_if bus ();

    audio_conditioner #(
        .HP_SHIFT  (8),
        .LP_SHIFT  (2),
        .RAMP_STEP (64),
        .ACC_W     (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int ncyc   = 0;
    int n_chk  = 0;
    int n_pass = 0;

    // Expected events indexed by cycle number (posedges seen).
    bit          ev  [NC];
    bit          eb  [NC];
    bit          er  [NC];
    bit          eos [NC];
    logic [15:0] eo  [NC];

    longint      m_xp, m_yp, m_z, m_gain;
    int          m_last;
    logic [15:0] m_exp_last;

    logic [15:0] cur_ain;
    bit          cur_snd, cur_mt;
    logic [15:0] last_out = 16'hFFFF;

    initial forever begin
        @(posedge clk);
        ncyc = ncyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, ncyc, act, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic model_reset();
        m_xp = 0; m_yp = 0; m_z = 0; m_gain = 0; m_last = -100;
    endtask

    // One conditioned sample computed straight from the filter equations.
    function automatic logic [15:0] model_sample(input logic [15:0] ain, input bit up);
        longint x, y, p;
        x = longint'(ain) - 32768;
        if (up) m_gain = (m_gain + STEP > FULL) ? FULL : m_gain + STEP;
        else    m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
        y    = x - m_xp + m_yp - (m_yp >>> HP);
        m_xp = x;
        m_yp = y;
        m_z  = m_z + ((y - m_z) >>> LP);
        p    = (m_z * m_gain) >>> 8;
        if (p > 32767)       p = 32767;
        else if (p < -32768) p = -32768;
        m_exp_last = p[15:0];
        return p[15:0];
    endfunction

    // Present inputs for one cycle and record what the model expects.
    task automatic drive(input bit se, input bit rv);
        int k;
        k = ncyc;
        bus.sample_en = se;
        bus.audio_in  = cur_ain;
        bus.sound_en  = cur_snd;
        bus.mute      = cur_mt;
        rst           = rv;
        if (k + 6 < NC) begin
            if (!rv) begin
                er[k+1] = 1'b1;
                for (int i = 1; i <= 4; i++) begin
                    ev[k+i] = 1'b0;
                    eb[k+i] = 1'b0;
                end
                model_reset();
            end else if (se) begin
                if (k >= m_last + 5) begin
                    m_last  = k;
                    eo[k+4] = model_sample(cur_ain, cur_snd && !cur_mt);
                    ev[k+4] = 1'b1;
                    for (int i = 1; i <= 4; i++) eb[k+i] = 1'b1;
                end else begin
                    eos[k+1] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        drive(1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b1);
    endtask

    // Every-cycle comparison against the model's expected events.
    initial begin : compare
        logic [15:0] held;
        bit          ovr;
        int          c;
        held = '0;
        ovr  = 1'b0;
        forever begin
            @(negedge clk);
            c = ncyc;
            if (c >= 1 && c < NC) begin
                if (er[c]) begin
                    held = '0;
                    ovr  = 1'b0;
                end else begin
                    if (ev[c])  held = eo[c];
                    if (eos[c]) ovr  = 1'b1;
                end
                check("out_valid", 32'(bus.out_valid), 32'(ev[c] && !er[c]));
                check("busy",      32'(bus.busy),      32'(eb[c] && !er[c]));
                check("overrun",   32'(bus.overrun),   32'(ovr));
                check("audio_out", 32'(bus.audio_out), 32'(held));
                if (bus.out_valid === 1'b1) last_out = bus.audio_out;
            end
        end
    end

    initial begin : stim
        int sat_hits;
        int negs;
        int gl [4];
        gl = '{192, 128, 64, 0};

        cur_ain = 16'h8000;
        cur_snd = 1'b1;
        cur_mt  = 1'b0;
        model_reset();
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);

        // Mid-scale input is zero after conversion.
        repeat (10) pulse();
        check("zero_in_out", 32'(last_out), 32'h0);
        check("gain_full_model", 32'(m_gain), 32'd256);

        // Step to +16384 at full gain.
        cur_ain = 16'hC000;
        pulse();
        check("step_out", 32'(last_out), 32'd4096);
        check("step_model_y", 32'(m_yp), 32'd16384);
        check("step_model_z", 32'(m_z), 32'd4096);
        check("step_model_out", 32'(m_exp_last), 32'd4096);
        repeat (20) pulse();

        // Mute ramps down, then unmute ramps back up.
        cur_mt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse();
            check("mute_gain", 32'(m_gain), 32'(gl[i]));
        end
        repeat (3) pulse();
        check("muted_out", 32'(last_out), 32'h0);
        cur_mt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse();
            check("unmute_gain", 32'(m_gain), 32'(64 * (i + 1)));
        end

        // Saturation on a large positive step after settling low.
        cur_ain = 16'h0000;
        repeat (300) pulse();
        cur_ain  = 16'hFFFF;
        sat_hits = 0;
        negs     = 0;
        repeat (20) begin
            pulse();
            if (last_out == 16'h7FFF) sat_hits++;
            if ($signed(last_out) < 0) negs++;
        end
        check("sat_reached", 32'(sat_hits > 0), 32'h1);
        check("sat_no_wrap", 32'(negs), 32'h0);

        // Overrun: second strobe two cycles after an accepted one.
        check("ovr_clear", 32'(bus.overrun), 32'h0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        repeat (5) drive(1'b0, 1'b1);
        check("ovr_sticky", 32'(bus.overrun), 32'h1);

        // Reset sampled at the end of the LPF cycle.
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("rst_audio_out", 32'(bus.audio_out), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        repeat (6) drive(1'b0, 1'b1);

        // Random traffic, spacing, controls and occasional resets.
        repeat (200) begin
            cur_ain = 16'($urandom);
            if ($urandom_range(0, 9) == 0)  cur_mt  = !cur_mt;
            if ($urandom_range(0, 14) == 0) cur_snd = !cur_snd;
            if ($urandom_range(0, 39) == 0) drive(1'b0, 1'b0);
            drive(1'b1, 1'b1);
            repeat ($urandom_range(1, 7)) drive(1'b0, 1'b1);
        end
        repeat (6) drive(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
